// File: rtl/picture_writer.sv
// Rectangle pixel writer: turns a row-major valid/ready pixel stream into image-BRAM writes.
// Optional PICTURE_WRITER_TRANSPARENT_EN suppresses the write strobe for TRANSPARENT pixels.
module picture_writer #(
    parameter int              WIDTH       = 240,
    parameter int              HEIGHT      = 160,
    parameter int              ADDR_W      = 16,
    parameter int              DATA_W      = 8,
    parameter logic [DATA_W-1:0] TRANSPARENT = 8'h00
) (
    input  logic              pixel_clk_in,
    input  logic              rst_n_in,
    input  logic              start_in,
    input  logic [10:0]       dst_x_in,
    input  logic [9:0]        dst_y_in,
    input  logic [10:0]       rect_w_in,
    input  logic [9:0]        rect_h_in,
    input  logic              pix_valid_in,
    input  logic [DATA_W-1:0] pix_data_in,
    output logic              pix_ready_out,
    output logic              we_out,
    output logic [ADDR_W-1:0] addr_out,
    output logic [DATA_W-1:0] data_out,
    output logic              busy_out,
    output logic              done_out,
    output logic              err_out
);

    typedef enum logic [1:0] {IDLE, WRITE, DONE} state_t;

    typedef struct packed {
        logic [10:0] w;
        logic [9:0]  h;
    } rect_t;

    state_t            state_q, state_d;
    rect_t             rect_q, rect_d;
    logic [10:0]       col_q, col_d;
    logic [9:0]        row_q, row_d;
    logic [ADDR_W-1:0] row_base_q, row_base_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              err_q, err_d;

    logic [11:0] sum_x;
    logic [10:0] sum_y;
    logic        reject;
    logic        skip;

`ifdef PICTURE_WRITER_TRANSPARENT_EN
    assign skip = (pix_data_in == TRANSPARENT);
`else
    logic unused_transparent;
    assign unused_transparent = ^TRANSPARENT;
    assign skip = 1'b0;
`endif

    // Widened sums so the bounds test cannot wrap.
    assign sum_x  = {1'b0, dst_x_in} + {1'b0, rect_w_in};
    assign sum_y  = {1'b0, dst_y_in} + {1'b0, rect_h_in};
    assign reject = (rect_w_in == '0) || (rect_h_in == '0) ||
                    (sum_x > 12'(WIDTH)) || (sum_y > 11'(HEIGHT));

    always_comb begin
        state_d    = state_q;
        rect_d     = rect_q;
        col_d      = col_q;
        row_d      = row_q;
        row_base_d = row_base_q;
        we_d       = 1'b0;
        addr_d     = addr_q;
        data_d     = data_q;
        err_d      = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_in) begin
                    if (reject) begin
                        err_d = 1'b1;
                    end else begin
                        rect_d.w   = rect_w_in;
                        rect_d.h   = rect_h_in;
                        col_d      = '0;
                        row_d      = '0;
                        row_base_d = ADDR_W'(dst_y_in) * ADDR_W'(WIDTH) + ADDR_W'(dst_x_in);
                        state_d    = WRITE;
                    end
                end
            end
            WRITE: begin
                if (pix_valid_in) begin
                    we_d   = !skip;
                    addr_d = row_base_q + ADDR_W'(col_q);
                    data_d = pix_data_in;
                    if (col_q == rect_q.w - 11'd1) begin
                        col_d      = '0;
                        row_d      = row_q + 10'd1;
                        row_base_d = row_base_q + ADDR_W'(WIDTH);
                        if (row_q == rect_q.h - 10'd1) state_d = DONE;
                    end else begin
                        col_d = col_q + 11'd1;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge pixel_clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q    <= IDLE;
            rect_q     <= '0;
            col_q      <= '0;
            row_q      <= '0;
            row_base_q <= '0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            data_q     <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            rect_q     <= rect_d;
            col_q      <= col_d;
            row_q      <= row_d;
            row_base_q <= row_base_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            err_q      <= err_d;
        end
    end

    assign pix_ready_out = (state_q == WRITE);
    assign busy_out      = (state_q != IDLE);
    assign done_out      = (state_q == DONE);
    assign we_out        = we_q;
    assign addr_out      = addr_q;
    assign data_out      = data_q;
    assign err_out       = err_q;

endmodule

// File: tb/tb_picture_writer.sv
// Scoreboard bench for picture_writer: expected writes are queued as beats are accepted
// and compared by a monitor as the write port fires.
module tb_picture_writer;

    logic        clk = 1'b0;
    logic        rst_n_in;
    logic        start_in;
    logic [10:0] dst_x_in;
    logic [9:0]  dst_y_in;
    logic [10:0] rect_w_in;
    logic [9:0]  rect_h_in;
    logic        pix_valid_in;
    logic [7:0]  pix_data_in;
    logic        pix_ready_out;
    logic        we_out;
    logic [15:0] addr_out;
    logic [7:0]  data_out;
    logic        busy_out;
    logic        done_out;
    logic        err_out;

    always #5 clk = ~clk;

    picture_writer dut (
        .pixel_clk_in (clk),
        .rst_n_in     (rst_n_in),
        .start_in     (start_in),
        .dst_x_in     (dst_x_in),
        .dst_y_in     (dst_y_in),
        .rect_w_in    (rect_w_in),
        .rect_h_in    (rect_h_in),
        .pix_valid_in (pix_valid_in),
        .pix_data_in  (pix_data_in),
        .pix_ready_out(pix_ready_out),
        .we_out       (we_out),
        .addr_out     (addr_out),
        .data_out     (data_out),
        .busy_out     (busy_out),
        .done_out     (done_out),
        .err_out      (err_out)
    );

    typedef struct {
        int addr;
        int data;
    } wr_t;

    wr_t        exp_q[$];
    logic [7:0] dq[$];
    int checks   = 0;
    int failures = 0;
    int done_cnt = 0;
    int err_cnt  = 0;
    int wr_cnt   = 0;

    // Write-port monitor: every strobe must match the head of the scoreboard.
    always @(negedge clk) begin
        wr_t e;
        if (rst_n_in) begin
            if (done_out) done_cnt++;
            if (err_out) err_cnt++;
            if (we_out) begin
                wr_cnt++;
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_write addr=%0d data=%0d", addr_out, data_out);
                end else begin
                    e = exp_q.pop_front();
                    if (addr_out !== e.addr[15:0] || data_out !== e.data[7:0]) begin
                        failures++;
                        $display("FAIL write addr=%0d data=%0d expected addr=%0d data=%0d",
                                 addr_out, data_out, e.addr, e.data);
                    end
                end
            end
        end
    end

    task automatic do_start(input int x, input int y, input int w, input int h);
        @(posedge clk); #1;
        start_in  = 1'b1;
        dst_x_in  = 11'(x);
        dst_y_in  = 10'(y);
        rect_w_in = 11'(w);
        rect_h_in = 10'(h);
        @(posedge clk); #1;
        start_in  = 1'b0;
    endtask

    // Streams up to lim beats; if lim covers the whole rectangle also checks done timing.
    task automatic stream(input int x, input int y, input int w, input int h,
                          input bit gaps, input int lim);
        int k   = 0;
        int cyc = 0;
        logic [7:0] d;
        wr_t e;
        while (k < lim && cyc < 60000) begin
            @(posedge clk); #1;
            d = (k < dq.size()) ? dq[k] : 8'(k);
            pix_data_in  = d;
            pix_valid_in = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
            @(negedge clk);
            if (pix_valid_in && pix_ready_out) begin
                e.addr = (y + k / w) * 240 + x + k % w;
                e.data = int'(d);
`ifdef PICTURE_WRITER_TRANSPARENT_EN
                if (d != 8'h00) exp_q.push_back(e);
`else
                exp_q.push_back(e);
`endif
                k++;
            end
            cyc++;
        end
        checks++;
        if (k != lim) begin
            failures++;
            $display("FAIL stream_timeout accepted=%0d expected=%0d", k, lim);
        end
        @(posedge clk); #1;
        pix_valid_in = 1'b0;
        if (lim == w * h) begin
            checks++;
            if (done_out !== 1'b1 || busy_out !== 1'b1 || pix_ready_out !== 1'b0) begin
                failures++;
                $display("FAIL done_cycle done=%b busy=%b ready=%b expected 1 1 0",
                         done_out, busy_out, pix_ready_out);
            end
            @(posedge clk); #1;
            checks++;
            if (done_out !== 1'b0 || busy_out !== 1'b0) begin
                failures++;
                $display("FAIL after_done done=%b busy=%b expected 0 0", done_out, busy_out);
            end
            checks++;
            if (exp_q.size() != 0) begin
                failures++;
                $display("FAIL missing_writes pending=%0d expected 0", exp_q.size());
            end
        end
    endtask

    task automatic test_reset();
        rst_n_in = 1'b0;
        #12;
        checks++;
        if ({pix_ready_out, we_out, busy_out, done_out, err_out} !== 5'b0 ||
            addr_out !== 16'd0 || data_out !== 8'd0) begin
            failures++;
            $display("FAIL reset_outputs ready=%b we=%b busy=%b done=%b err=%b addr=%0d data=%0d expected all 0",
                     pix_ready_out, we_out, busy_out, done_out, err_out, addr_out, data_out);
        end
        @(posedge clk); #1;
        rst_n_in = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (busy_out !== 1'b0 || pix_ready_out !== 1'b0) begin
            failures++;
            $display("FAIL idle_after_reset busy=%b ready=%b expected 0 0", busy_out, pix_ready_out);
        end
    endtask

    task automatic test_full_frame();
        int w0 = wr_cnt;
        int d0 = done_cnt;
        dq.delete();
        do_start(0, 0, 240, 160);
        checks++;
        if (busy_out !== 1'b1 || err_out !== 1'b0) begin
            failures++;
            $display("FAIL full_start busy=%b err=%b expected 1 0", busy_out, err_out);
        end
        stream(0, 0, 240, 160, 1'b0, 38400);
        checks++;
`ifdef PICTURE_WRITER_TRANSPARENT_EN
        if (wr_cnt - w0 != 38400 - 150) begin
`else
        if (wr_cnt - w0 != 38400) begin
`endif
            failures++;
            $display("FAIL full_write_count got=%0d", wr_cnt - w0);
        end
        checks++;
        if (done_cnt - d0 != 1) begin
            failures++;
            $display("FAIL full_done_count got=%0d expected 1", done_cnt - d0);
        end
    endtask

    task automatic test_sub_rect();
        dq.delete();
        for (int i = 1; i <= 6; i++) dq.push_back(8'(i));
        do_start(10, 5, 3, 2);
        stream(10, 5, 3, 2, 1'b1, 6);
    endtask

    task automatic test_rejects();
        int x[4] = '{238, 0, 0, 0};
        int y[4] = '{0, 0, 0, 150};
        int w[4] = '{3, 0, 1, 1};
        int h[4] = '{1, 1, 0, 11};
        for (int i = 0; i < 4; i++) begin
            do_start(x[i], y[i], w[i], h[i]);
            checks++;
            if (err_out !== 1'b1 || busy_out !== 1'b0) begin
                failures++;
                $display("FAIL reject_%0d err=%b busy=%b expected 1 0", i, err_out, busy_out);
            end
            @(posedge clk); #1;
            checks++;
            if (err_out !== 1'b0 || busy_out !== 1'b0) begin
                failures++;
                $display("FAIL reject_pulse_%0d err=%b busy=%b expected 0 0", i, err_out, busy_out);
            end
        end
        dq.delete();
        dq.push_back(8'h3c);
        do_start(0, 159, 1, 1);
        checks++;
        if (err_out !== 1'b0 || busy_out !== 1'b1) begin
            failures++;
            $display("FAIL corner_accept err=%b busy=%b expected 0 1", err_out, busy_out);
        end
        stream(0, 159, 1, 1, 1'b0, 1);
    endtask

    task automatic test_start_while_busy();
        int d0 = done_cnt;
        int e0 = err_cnt;
        int w0 = wr_cnt;
        dq.delete();
        for (int i = 0; i < 4; i++) dq.push_back(8'(8'h40 + i));
        do_start(0, 0, 4, 1);
        do_start(100, 100, 2, 2);
        stream(0, 0, 4, 1, 1'b0, 4);
        checks++;
        if (done_cnt - d0 != 1 || err_cnt != e0 || wr_cnt - w0 != 4) begin
            failures++;
            $display("FAIL busy_start done=%0d err=%0d writes=%0d expected 1 0 4",
                     done_cnt - d0, err_cnt - e0, wr_cnt - w0);
        end
    endtask

    task automatic test_reset_mid_op();
        int d0;
        dq.delete();
        for (int i = 0; i < 16; i++) dq.push_back(8'(8'h80 + i));
        do_start(0, 0, 4, 4);
        stream(0, 0, 4, 4, 1'b0, 5);
        @(negedge clk);
        d0 = done_cnt;
        @(posedge clk); #1;
        rst_n_in = 1'b0;
        #1;
        checks++;
        if ({pix_ready_out, we_out, busy_out, done_out, err_out} !== 5'b0 ||
            addr_out !== 16'd0 || data_out !== 8'd0) begin
            failures++;
            $display("FAIL midop_reset ready=%b we=%b busy=%b done=%b addr=%0d expected all 0",
                     pix_ready_out, we_out, busy_out, done_out, addr_out);
        end
        repeat (3) @(posedge clk);
        #1;
        rst_n_in = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        checks++;
        if (done_cnt != d0 || exp_q.size() != 0 || busy_out !== 1'b0) begin
            failures++;
            $display("FAIL midop_abort done=%0d pending=%0d busy=%b expected 0 0 0",
                     done_cnt - d0, exp_q.size(), busy_out);
        end
        dq.delete();
        dq.push_back(8'h11);
        dq.push_back(8'h22);
        do_start(0, 0, 2, 1);
        stream(0, 0, 2, 1, 1'b0, 2);
    endtask

    task automatic test_transparent();
        int w0 = wr_cnt;
        dq.delete();
        dq.push_back(8'd5);
        dq.push_back(8'd0);
        dq.push_back(8'd7);
        dq.push_back(8'd0);
        do_start(0, 0, 4, 1);
        stream(0, 0, 4, 1, 1'b0, 4);
        checks++;
`ifdef PICTURE_WRITER_TRANSPARENT_EN
        if (wr_cnt - w0 != 2) begin
`else
        if (wr_cnt - w0 != 4) begin
`endif
            failures++;
            $display("FAIL transparent_count got=%0d", wr_cnt - w0);
        end
    endtask

    initial begin
        rst_n_in     = 1'b0;
        start_in     = 1'b0;
        dst_x_in     = '0;
        dst_y_in     = '0;
        rect_w_in    = '0;
        rect_h_in    = '0;
        pix_valid_in = 1'b0;
        pix_data_in  = '0;
        test_reset();
        test_sub_rect();
        test_rejects();
        test_start_while_busy();
        test_reset_mid_op();
        test_transparent();
        test_full_frame();
        repeat (3) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
